// File: rtl/geo_pixel_address_gen.sv
// Pixel address generator: clips screen-space pixel commands against the destination bitmap and formats 40-bit pixel-writer commands.
// Optional clip counter enabled by defining GEO_PAG_CLIP_COUNT_EN; otherwise clip_count is tied to zero.
module geo_pixel_address_gen #(
   parameter int unsigned PIPE_DEPTH = 3,
   parameter int unsigned CLIP_CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [3:0]            cmd_code,
   input  logic [11:0]           cmd_x,
   input  logic [11:0]           cmd_y,
   input  logic [7:0]            cmd_colour,
   input  logic                  cfg_wr,
   output logic                  cfg_ready,
   input  logic [19:0]           cfg_base,
   input  logic [11:0]           cfg_width,
   input  logic [3:0]            cfg_bpp,
   input  logic [11:0]           cfg_xmax,
   input  logic [11:0]           cfg_ymax,
   input  logic                  draw_busy,
   output logic                  pix_cmd_rdy,
   output logic [39:0]           pix_cmd_out,
   output logic [CLIP_CNT_W-1:0] clip_count,
   input  logic                  clip_clr
);

   localparam int unsigned ADDR_W  = 20;
   localparam int unsigned COORD_W = 12;
   localparam int unsigned YW      = 11;
   localparam int unsigned PROD_W  = 23;
   localparam int unsigned SUM_W   = 24;

   typedef struct packed {
      logic [3:0]        code;
      logic [7:0]        colour;
      logic [3:0]        bpp;
      logic [3:0]        target;
      logic [ADDR_W-1:0] addr;
   } pix_cmd_t;

   if (PIPE_DEPTH != 3) begin : g_depth_chk
      $error("geo_pixel_address_gen: PIPE_DEPTH is informational and must be 3");
   end

   // Configuration registers
   logic [ADDR_W-1:0]  cfg_base_q;
   logic [COORD_W-1:0] cfg_width_q;
   logic [3:0]         cfg_bpp_q;
   logic [COORD_W-1:0] cfg_xmax_q;
   logic [COORD_W-1:0] cfg_ymax_q;

   // Pipeline registers
   logic               s1_valid, s2_valid, s3_valid;
   logic [3:0]         s1_code, s2_code;
   logic [7:0]         s1_colour, s2_colour;
   logic [3:0]         s1_bpp, s2_bpp;
   logic [3:0]         s1_target, s2_target;
   logic               s1_pix, s2_pix;
   logic [COORD_W-1:0] s1_xw, s2_xw;
   logic [YW-1:0]      s1_y;
   logic [PROD_W-1:0]  s2_prod;
   pix_cmd_t           s3_cmd;

   logic               adv;
   logic               cfg_wr_accept;
   logic               bpp_ok;
   logic               accept;
   logic               is_pix;
   logic               clip;
   logic               clip_inc;
   logic [2:0]         sh;
   logic [3:0]         tgt_mask;
   logic [COORD_W-1:0] xw;
   logic [3:0]         tgt;
   logic [ADDR_W-1:0]  addr_sum;
   logic [3:0]         unused_sum_hi;

   assign adv           = !draw_busy;
   assign cfg_ready     = !(s1_valid || s2_valid || s3_valid) && !cmd_valid;
   assign cfg_wr_accept = cfg_wr && cfg_ready;
   assign cmd_ready     = adv && !cfg_wr_accept;
   assign accept        = cmd_valid && cmd_ready;
   assign bpp_ok        = cfg_bpp inside {4'd0, 4'd1, 4'd3, 4'd7, 4'd15};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cfg_base_q  <= '0;
         cfg_width_q <= '0;
         cfg_bpp_q   <= 4'd15;
         cfg_xmax_q  <= '0;
         cfg_ymax_q  <= '0;
      end else if (cfg_wr_accept && bpp_ok) begin
         cfg_base_q  <= cfg_base;
         cfg_width_q <= cfg_width;
         cfg_bpp_q   <= cfg_bpp;
         cfg_xmax_q  <= cfg_xmax;
         cfg_ymax_q  <= cfg_ymax;
      end
   end

   // Stage 1 decode: sub-word shift, clip test, word/target split
   always_comb begin
      is_pix   = cmd_code inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6};
      sh       = 3'd0;
      tgt_mask = 4'h0;
      case (cfg_bpp_q)
         4'd0:    begin sh = 3'd4; tgt_mask = 4'hF; end
         4'd1:    begin sh = 3'd3; tgt_mask = 4'h7; end
         4'd3:    begin sh = 3'd2; tgt_mask = 4'h3; end
         4'd7:    begin sh = 3'd1; tgt_mask = 4'h1; end
         default: begin sh = 3'd0; tgt_mask = 4'h0; end
      endcase
      clip = is_pix && (cmd_x[COORD_W-1] || cmd_y[COORD_W-1] ||
                        (cmd_x > cfg_xmax_q) || (cmd_y > cfg_ymax_q));
      xw   = cmd_x >> sh;
      tgt  = cmd_x[3:0] & tgt_mask;
   end

   assign clip_inc = accept && clip;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid  <= 1'b0;
         s1_code   <= '0;
         s1_colour <= '0;
         s1_bpp    <= '0;
         s1_target <= '0;
         s1_pix    <= 1'b0;
         s1_xw     <= '0;
         s1_y      <= '0;
      end else if (adv) begin
         s1_valid  <= accept && !clip;
         s1_code   <= cmd_code;
         s1_colour <= cmd_colour;
         s1_pix    <= is_pix;
         s1_bpp    <= is_pix ? cfg_bpp_q : 4'd0;
         s1_target <= is_pix ? tgt : 4'd0;
         s1_xw     <= is_pix ? xw : '0;
         s1_y      <= is_pix ? cmd_y[YW-1:0] : '0;
      end
   end

   // Stage 2: row offset multiply
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_valid  <= 1'b0;
         s2_code   <= '0;
         s2_colour <= '0;
         s2_bpp    <= '0;
         s2_target <= '0;
         s2_pix    <= 1'b0;
         s2_xw     <= '0;
         s2_prod   <= '0;
      end else if (adv) begin
         s2_valid  <= s1_valid;
         s2_code   <= s1_code;
         s2_colour <= s1_colour;
         s2_bpp    <= s1_bpp;
         s2_target <= s1_target;
         s2_pix    <= s1_pix;
         s2_xw     <= s1_xw;
         s2_prod   <= PROD_W'(s1_y) * PROD_W'(cfg_width_q);
      end
   end

   // Stage 3: final address, wrapping modulo 2^20
   assign {unused_sum_hi, addr_sum} = SUM_W'(cfg_base_q) + SUM_W'(s2_prod) + SUM_W'(s2_xw);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s3_valid <= 1'b0;
         s3_cmd   <= '0;
      end else if (adv) begin
         s3_valid      <= s2_valid;
         s3_cmd.code   <= s2_code;
         s3_cmd.colour <= s2_colour;
         s3_cmd.bpp    <= s2_bpp;
         s3_cmd.target <= s2_target;
         s3_cmd.addr   <= s2_pix ? addr_sum : '0;
      end
   end

   assign pix_cmd_out = s3_cmd;
   assign pix_cmd_rdy = s3_valid && !draw_busy;

`ifdef GEO_PAG_CLIP_COUNT_EN
   // Saturating clip counter; clear has priority over increment
   logic [CLIP_CNT_W-1:0] clip_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clip_cnt_q <= '0;
      end else if (clip_clr) begin
         clip_cnt_q <= '0;
      end else if (clip_inc && !(&clip_cnt_q)) begin
         clip_cnt_q <= clip_cnt_q + CLIP_CNT_W'(1);
      end
   end

   assign clip_count = clip_cnt_q;
`else
   logic unused_clip;
   assign unused_clip = clip_clr | clip_inc;
   assign clip_count  = '0;
`endif

endmodule
